// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the Ethernet TX framing path.
//   tx_fcs_state_t   : states of the pad/FCS insertion FSM
//   CRC32_POLY       : IEEE 802.3 CRC-32 generator polynomial (normal form)
//   CRC32_INIT       : CRC register preset value
//   CRC32_RESIDUE    : register value left after running a good frame plus its FCS
//   ETH_MIN_PAYLOAD  : minimum frame length in bytes before the FCS
// ----------------------------------------------------------------------------
package mac_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_DATA,
      TX_PAD,
      TX_FCS
   } tx_fcs_state_t;

   localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
   localparam int          ETH_MIN_PAYLOAD = 60;

endpackage

// File: rtl/mac_tx_fcs_insert_if.sv
// ----------------------------------------------------------------------------
// mac_tx_fcs_insert_if
// 8-bit AXI-Stream byte channel with a frame-bad sideband.
//   tdata  : byte
//   tvalid : byte valid (source)
//   tready : byte accepted (sink)
//   tlast  : last byte of frame
//   tuser  : frame-bad flag, meaningful on the tlast beat
// modport master drives the stream, modport slave receives it.
// ----------------------------------------------------------------------------
interface mac_tx_fcs_insert_if;

   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tuser,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tuser,
      output tready
   );

endinterface

// File: rtl/mac_lfsr.sv
// ----------------------------------------------------------------------------
// mac_lfsr
// Galois-form LFSR that absorbs DATA_WIDTH bits per enabled cycle.
// With REVERSE=1 the register shifts right, consumes data LSB first and uses
// the bit-reversed polynomial (reflected CRC form).
//   clk                   : clock
//   rst_n                 : asynchronous active-low reset to LFSR_RESET_STATE
//   rst                   : synchronous preset; the register is treated as
//                           lfsr_initial_state_in for this cycle's update
//   data_in               : data word to absorb
//   data_valid_in         : absorb data_in this cycle
//   lfsr_initial_state_in : preset value used while rst is high
//   lfsr_state_out        : next register value (includes this cycle's data)
// ----------------------------------------------------------------------------
module mac_lfsr #(
   parameter int                    LFSR_WIDTH       = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY        = 32'h04C11DB7,
   parameter bit                    REVERSE          = 1'b1,
   parameter int                    DATA_WIDTH       = 8,
   parameter logic [LFSR_WIDTH-1:0] LFSR_RESET_STATE = '1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   input  logic [LFSR_WIDTH-1:0] lfsr_initial_state_in,
   output logic [LFSR_WIDTH-1:0] lfsr_state_out
);

   function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
      logic [LFSR_WIDTH-1:0] r;
      for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
      return r;
   endfunction

   localparam logic [LFSR_WIDTH-1:0] POLY_REV = bit_rev(LFSR_POLY);

   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s,
                                                       input logic [DATA_WIDTH-1:0] d);
      logic [LFSR_WIDTH-1:0] r;
      logic                  fb;
      r = s;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (REVERSE) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ POLY_REV;
         end else begin
            fb = r[LFSR_WIDTH-1] ^ d[DATA_WIDTH-1-i];
            r  = r << 1;
            if (fb) r = r ^ LFSR_POLY;
         end
      end
      return r;
   endfunction

   logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_base;

   // The preset is applied combinationally so that a word arriving in the
   // same cycle as rst is absorbed on top of the initial value.
   always_comb begin
      lfsr_base = rst ? lfsr_initial_state_in : lfsr_q;
      lfsr_d    = data_valid_in ? lfsr_step(lfsr_base, data_in) : lfsr_base;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_RESET_STATE;
      else        lfsr_q <= lfsr_d;
   end

   assign lfsr_state_out = lfsr_d;

endmodule

// File: rtl/mac_tx_fcs_insert.sv
// ----------------------------------------------------------------------------
// mac_tx_fcs_insert
// Ethernet TX framing stage: passes payload bytes (DA..end of payload),
// zero-pads short frames to MIN_FRAME_LEN and appends the 4-byte CRC-32 FCS,
// least significant byte first. A frame flagged bad on its tlast beat gets a
// non-inverted FCS so every receiver rejects it.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   s_axis : payload byte stream in (tuser = frame bad, on tlast only)
//   m_axis : payload/pad/FCS byte stream out (tlast/tuser on 4th FCS byte)
// One output register; a byte accepted on s_axis appears on m_axis the
// following cycle, at one byte per clock.
// ----------------------------------------------------------------------------
module mac_tx_fcs_insert
   import mac_pkg::*;
#(
   parameter int MIN_FRAME_LEN = ETH_MIN_PAYLOAD,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mac_tx_fcs_insert_if.slave   s_axis,
   mac_tx_fcs_insert_if.master  m_axis
);

   localparam logic [CNT_WIDTH:0] MIN_LEN = (CNT_WIDTH+1)'(MIN_FRAME_LEN);

   tx_fcs_state_t          state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [1:0]             idx_q, idx_d;
   logic [31:0]            fcs_q, fcs_d;
   logic                   bad_q, bad_d;
   logic [7:0]             tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tlast_q, tlast_d;
   logic                   tuser_q, tuser_d;
   logic                   rdy_q;

   logic                   load_en;
   logic                   s_accept;
   logic                   s_fire;
   logic                   needs_pad;
   logic                   crc_rst;
   logic                   crc_en;
   logic [7:0]             crc_byte;
   logic [31:0]            next_crc;

   assign load_en   = !tvalid_q || m_axis.tready;
   // rdy_q keeps tready low until the first clock after reset release.
   assign s_accept  = rdy_q && load_en && (state_q == TX_IDLE || state_q == TX_DATA);
   assign s_fire    = s_accept && s_axis.tvalid;
   // Saturating count; a saturated count is never below MIN_LEN.
   assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign needs_pad = ({1'b0, cnt_inc} < MIN_LEN);
   assign crc_rst   = (state_q == TX_IDLE);

   mac_lfsr #(
      .LFSR_WIDTH       (32),
      .LFSR_POLY        (CRC32_POLY),
      .REVERSE          (1'b1),
      .DATA_WIDTH       (8),
      .LFSR_RESET_STATE (CRC32_INIT)
   ) u_crc (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .rst                   (crc_rst),
      .data_in               (crc_byte),
      .data_valid_in         (crc_en),
      .lfsr_initial_state_in (CRC32_INIT),
      .lfsr_state_out        (next_crc)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      fcs_d    = fcs_q;
      bad_d    = bad_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      crc_en   = 1'b0;
      crc_byte = 8'h00;

      case (state_q)
         TX_IDLE, TX_DATA: begin
            // IDLE holds count at zero, so both states share the data path.
            if (load_en) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
            end
            if (s_fire) begin
               tdata_d  = s_axis.tdata;
               tvalid_d = 1'b1;
               crc_en   = 1'b1;
               crc_byte = s_axis.tdata;
               cnt_d    = cnt_inc;
               state_d  = TX_DATA;
               if (s_axis.tlast) begin
                  bad_d = s_axis.tuser;
                  if (needs_pad) begin
                     state_d = TX_PAD;
                  end else begin
                     state_d = TX_FCS;
                     fcs_d   = s_axis.tuser ? next_crc : ~next_crc;
                  end
               end
            end
         end
         TX_PAD: begin
            if (load_en) begin
               tdata_d  = 8'h00;
               tvalid_d = 1'b1;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
               crc_en   = 1'b1;
               cnt_d    = cnt_inc;
               if (!needs_pad) begin
                  state_d = TX_FCS;
                  fcs_d   = bad_q ? next_crc : ~next_crc;
               end
            end
         end
         TX_FCS: begin
            if (load_en) begin
               tdata_d  = fcs_q[{idx_q, 3'b000} +: 8];
               tvalid_d = 1'b1;
               tlast_d  = (idx_q == 2'd3);
               tuser_d  = bad_q && (idx_q == 2'd3);
               idx_d    = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = TX_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= TX_IDLE;
         cnt_q    <= '0;
         idx_q    <= 2'd0;
         fcs_q    <= '0;
         bad_q    <= 1'b0;
         tdata_q  <= 8'h00;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         fcs_q    <= fcs_d;
         bad_q    <= bad_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         rdy_q    <= 1'b1;
      end
   end

   assign s_axis.tready = s_accept;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tuser  = tuser_q;

endmodule

// File: tb/tb_mac_tx_fcs_insert.sv
// ----------------------------------------------------------------------------
// tb_mac_tx_fcs_insert
// Bench for mac_tx_fcs_insert: dut0 runs with padding disabled, dut1 with the
// default 60-byte minimum. Expected output frames for dut1 come from a
// byte-level model (pad to 60, CRC-32 over the padded frame, append FCS).
// ----------------------------------------------------------------------------
module tb_mac_tx_fcs_insert;
   import mac_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mac_tx_fcs_insert_if s0 ();
   mac_tx_fcs_insert_if m0 ();
   mac_tx_fcs_insert_if s1 ();
   mac_tx_fcs_insert_if m1 ();

   mac_tx_fcs_insert #(.MIN_FRAME_LEN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0)
   );

   mac_tx_fcs_insert dut1 (
      .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1)
   );

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   bit          rnd_rdy  = 1'b0;
   logic [7:0]  pl[$];
   logic [9:0]  exp_q[$];
   logic [9:0]  got_q[$];
   logic [9:0]  got0_q[$];
   int          got_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference CRC register after absorbing bytes LSB first, no final inversion.
   function automatic logic [31:0] crc32_raw(input logic [7:0] q[$]);
      logic [31:0] c;
      c = CRC32_INIT;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   task automatic add_expected(input bit bad);
      logic [7:0]  f[$];
      logic [31:0] crc, fcs;
      f = pl;
      while (f.size() < ETH_MIN_PAYLOAD) f.push_back(8'h00);
      crc = crc32_raw(f);
      fcs = bad ? crc : ~crc;
      foreach (f[i]) exp_q.push_back({2'b00, f[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, bad && (k == 3), fcs[8*k +: 8]});
   endtask

   task automatic build_random(input int len);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
   endtask

   task automatic idle1(input int n);
      s1.tvalid = 1'b0;
      s1.tdata  = 8'($urandom);
      s1.tlast  = 1'($urandom);
      s1.tuser  = 1'($urandom);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drv_beat(input bit d1, input logic [7:0] b, input logic last, input logic user);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      if (d1) begin
         s1.tdata = b; s1.tlast = last; s1.tuser = user; s1.tvalid = 1'b1;
      end else begin
         s0.tdata = b; s0.tlast = last; s0.tuser = user; s0.tvalid = 1'b1;
      end
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = d1 ? s1.tready : s0.tready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) chk("in_handshake_timeout", 32'(n), 32'd0);
   endtask

   task automatic send_pl(input bit bad, input bit gaps, input bit hold);
      add_expected(bad);
      for (int i = 0; i < pl.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle1($urandom_range(1, 3));
         drv_beat(1'b1, pl[i], i == pl.size() - 1,
                  (i == pl.size() - 1) ? bad : 1'($urandom));
      end
      if (!hold) idle1(0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m1.tvalid) && n < 20000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic clear_got();
      got_q.delete();
      got_cyc.delete();
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      m1.tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         m1.tready = rnd_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // dut1 scoreboard and stall-stability monitor
   initial begin : mon1
      logic [9:0] beat, prev_beat, e;
      bit         prev_stall;
      prev_stall = 1'b0;
      prev_beat  = '0;
      forever begin
         @(negedge clk);
         beat = {m1.tlast, m1.tuser, m1.tdata};
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", 32'(m1.tvalid), 32'd1);
               chk("stall_beat", 32'(beat), 32'(prev_beat));
            end
            prev_stall = m1.tvalid && !m1.tready;
            prev_beat  = beat;
            if (m1.tvalid && m1.tready) begin
               got_q.push_back(beat);
               got_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat_queue", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_last_user_data", 32'(beat), 32'(e));
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && m0.tvalid && m0.tready) got0_q.push_back({m0.tlast, m0.tuser, m0.tdata});
   end

   initial begin : main
      logic [7:0]  exp1 [13];
      logic [31:0] good_fcs, bad_fcs, resid;
      logic [7:0]  outb[$];
      int          n, len;

      exp1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
      rst_n = 1'b0;
      s0.tvalid = 1'b0; s0.tdata = 8'h00; s0.tlast = 1'b0; s0.tuser = 1'b0;
      s1.tvalid = 1'b0; s1.tdata = 8'h00; s1.tlast = 1'b0; s1.tuser = 1'b0;
      m0.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 32'(m1.tvalid), 32'd0);
      chk("rst_m_tdata",  32'(m1.tdata),  32'd0);
      chk("rst_m_tlast",  32'(m1.tlast),  32'd0);
      chk("rst_m_tuser",  32'(m1.tuser),  32'd0);
      chk("rst_s_tready", 32'(s1.tready), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Check value "123456789", padding disabled
      for (int i = 0; i < 9; i++) drv_beat(1'b0, exp1[i], i == 8, 1'b0);
      s0.tvalid = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      chk("t1_len", 32'(got0_q.size()), 32'd13);
      for (int i = 0; i < 13 && i < got0_q.size(); i++)
         chk("t1_beat", 32'(got0_q[i]), 32'({i == 12, 1'b0, exp1[i]}));

      // 14-byte all-FF header -> padded to 60 + FCS, residue over output
      clear_got();
      pl.delete();
      for (int i = 0; i < 14; i++) pl.push_back(8'hFF);
      send_pl(1'b0, 1'b0, 1'b0);
      wait_drain();
      chk("t2_len", 32'(got_q.size()), 32'd64);
      outb.delete();
      foreach (got_q[i]) outb.push_back(got_q[i][7:0]);
      resid = crc32_raw(outb);
      chk("t2_residue", resid, CRC32_RESIDUE);

      // Lengths around the minimum
      foreach (exp1[j]) begin
         if (j < 3) begin
            len = (j == 0) ? 60 : (j == 1) ? 61 : 59;
            clear_got();
            build_random(len);
            send_pl(1'b0, 1'b0, 1'b0);
            wait_drain();
            chk("t3_len", 32'(got_q.size()), 32'((len < 60) ? 64 : len + 4));
         end
      end

      // Bad frame: FCS is the complement of the good FCS
      build_random(64);
      clear_got();
      send_pl(1'b0, 1'b0, 1'b0);
      wait_drain();
      n = got_q.size();
      good_fcs = (n >= 4) ? {got_q[n-1][7:0], got_q[n-2][7:0], got_q[n-3][7:0], got_q[n-4][7:0]} : 32'h0;
      clear_got();
      send_pl(1'b1, 1'b0, 1'b0);
      wait_drain();
      n = got_q.size();
      bad_fcs = (n >= 4) ? {got_q[n-1][7:0], got_q[n-2][7:0], got_q[n-3][7:0], got_q[n-4][7:0]} : 32'h0;
      chk("t4_fcs_complement", bad_fcs, ~good_fcs);
      chk("t4_last_tuser", 32'((n > 0) ? got_q[n-1][8] : 1'b0), 32'd1);

      // Back-to-back frames with full throughput: no output bubble
      clear_got();
      build_random(60);
      send_pl(1'b0, 1'b0, 1'b1);
      build_random(60);
      send_pl(1'b0, 1'b0, 1'b0);
      wait_drain();
      n = got_cyc.size();
      chk("b2b_contiguous", 32'((n > 0) ? got_cyc[n-1] - got_cyc[0] + 1 : 0), 32'd128);

      // Random backpressure and input gaps, 200 frames
      rnd_rdy = 1'b1;
      for (int f = 0; f < 200; f++) begin
         len = (f % 25 == 0) ? $urandom_range(1000, 1518) : $urandom_range(1, 100);
         if (f == 7) len = 1;
         if (f == 50) len = 1518;
         build_random(len);
         send_pl(1'($urandom), 1'b1, f != 199);
      end
      wait_drain();
      rnd_rdy = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Reset during padding
      build_random(14);
      send_pl(1'b0, 1'b0, 1'b0);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("pad_rst_tvalid", 32'(m1.tvalid), 32'd0);
      chk("pad_rst_tdata",  32'(m1.tdata),  32'd0);
      chk("pad_rst_tready", 32'(s1.tready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      build_random(20);
      send_pl(1'b0, 1'b0, 1'b0);
      wait_drain();

      // Reset during FCS emission
      build_random(60);
      send_pl(1'b0, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("fcs_rst_tvalid", 32'(m1.tvalid), 32'd0);
      chk("fcs_rst_tlast",  32'(m1.tlast),  32'd0);
      chk("fcs_rst_tdata",  32'(m1.tdata),  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      clear_got();
      build_random(70);
      send_pl(1'b0, 1'b0, 1'b0);
      wait_drain();
      chk("post_rst_len", 32'(got_q.size()), 32'd74);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
